// File: rtl/crypto_intr_ctrl_pkg.sv
// Shared definitions for the crypto interrupt controller: word offsets,
// source bit indices, coalescing FSM states and a popcount helper.
package crypto_intr_ctrl_pkg;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SRC_RSA = 0;
  localparam int unsigned SRC_AES = 1;
  localparam int unsigned SRC_SHA = 2;

  // Word offsets as decoded from haddr[7:2]
  localparam logic [5:0] OFF_RAW  = 6'h00;
  localparam logic [5:0] OFF_PEND = 6'h01;
  localparam logic [5:0] OFF_MASK = 6'h02;
  localparam logic [5:0] OFF_STAT = 6'h03;
  localparam logic [5:0] OFF_COAL = 6'h04;
  localparam logic [5:0] OFF_CNT  = 6'h05;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2
  } coal_state_e;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/crypto_intr_ctrl_if.sv
// AHB-Lite slave window signals for the crypto interrupt controller.
interface crypto_intr_ctrl_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/crypto_intr_coalesce.sv
// Coalescing FSM: merges masked edge events by count threshold or timeout
// into a single registered interrupt line.
module crypto_intr_coalesce
  import crypto_intr_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_W = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] mev,
  input  logic [NUM_SRC-1:0] stat,
  input  logic [CNT_W-1:0]   thr,
  input  logic [TIMER_W-1:0] tmo,
  output logic               irq_out
);

  coal_state_e        state_q, state_d;
  logic [CNT_W-1:0]   evt_q, evt_d;
  logic [TIMER_W-1:0] tmr_q, tmr_d;
  logic               irq_q, irq_d;
  logic [CNT_W-1:0]   n_ev;
  logic [CNT_W:0]     evt_wide;
  logic [CNT_W-1:0]   evt_sum;

  always_comb begin
    n_ev     = CNT_W'(popcount3(mev));
    evt_wide = {1'b0, evt_q} + {1'b0, n_ev};
    evt_sum  = evt_wide[CNT_W] ? '1 : evt_wide[CNT_W-1:0];
    state_d  = state_q;
    evt_d    = evt_q;
    tmr_d    = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (n_ev != '0) begin
          evt_d   = n_ev;
          tmr_d   = '0;
          state_d = (n_ev >= thr || thr <= CNT_W'(1)) ? ST_ASSERT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        evt_d = evt_sum;
        if (tmr_q != '1) tmr_d = tmr_q + TIMER_W'(1);
        // Timeout compares the post-increment value so it fires N cycles after the first event
        if (evt_sum >= thr)                   state_d = ST_ASSERT;
        else if (tmo != '0 && tmr_d == tmo)   state_d = ST_ASSERT;
        else if (stat == '0)                  state_d = ST_IDLE;
      end
      ST_ASSERT: begin
        if (stat == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      evt_q   <= '0;
      tmr_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      tmr_q   <= tmr_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_out = irq_q;

endmodule

// File: rtl/crypto_intr_ctrl.sv
// Interrupt aggregation for the crypto core: edge capture, W1C pending,
// mask, per-source event counters and an AHB-Lite register window.
module crypto_intr_ctrl
  import crypto_intr_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_W = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               hclk,
  input  logic               hrst_b,
  crypto_intr_ctrl_if.slave  ahb,
  input  logic               rsa_intr,
  input  logic               aes_intr,
  input  logic               sha_intr,
  output logic               irq_out
);

  logic [NUM_SRC-1:0] src_now, src_q, src_edge;
  logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [NUM_SRC-1:0] mev, stat_nxt;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [TIMER_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic               wr_q, wr_d, rd_q, rd_d;
  logic [5:0]         addr_q, addr_d;
  logic               wr_pend, wr_mask, wr_coal, wr_cnt;
  logic [31:0]        rdata;
  logic               unused_ahb;

  assign unused_ahb = ^{ahb.hsize, ahb.hprot, ahb.haddr[31:8], ahb.haddr[1:0],
                        ahb.hwdata[31:CNT_W+TIMER_W]};

  always_comb begin
    src_now  = {sha_intr, aes_intr, rsa_intr};
    src_edge = src_now & ~src_q;

    wr_d   = ahb.hsel & ahb.htrans[1] & ahb.hwrite;
    rd_d   = ahb.hsel & ahb.htrans[1] & ~ahb.hwrite;
    addr_d = (ahb.hsel & ahb.htrans[1]) ? ahb.haddr[7:2] : addr_q;

    wr_pend = wr_q && (addr_q == OFF_PEND);
    wr_mask = wr_q && (addr_q == OFF_MASK);
    wr_coal = wr_q && (addr_q == OFF_COAL);
    wr_cnt  = wr_q && (addr_q == OFF_CNT);

    // New edges are OR-ed after the W1C so a coincident set wins
    pend_d = (pend_q & ~(wr_pend ? ahb.hwdata[NUM_SRC-1:0] : '0)) | src_edge;
    mask_d = wr_mask ? ahb.hwdata[NUM_SRC-1:0] : mask_q;
    thr_d  = wr_coal ? ahb.hwdata[CNT_W-1:0] : thr_q;
    tmo_d  = wr_coal ? ahb.hwdata[CNT_W +: TIMER_W] : tmo_q;

    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = wr_cnt ? '0 : cnt_q[i];
      if (src_edge[i] && cnt_d[i] != '1) cnt_d[i] = cnt_d[i] + CNT_W'(1);
    end

    mev      = src_edge & mask_q;
    stat_nxt = pend_d & mask_d;
  end

  always_comb begin
    rdata = '0;
    if (rd_q) begin
      case (addr_q)
        OFF_RAW:  rdata[NUM_SRC-1:0] = src_q;
        OFF_PEND: rdata[NUM_SRC-1:0] = pend_q;
        OFF_MASK: rdata[NUM_SRC-1:0] = mask_q;
        OFF_STAT: rdata[NUM_SRC-1:0] = pend_q & mask_q;
        OFF_COAL: rdata[CNT_W+TIMER_W-1:0] = {tmo_q, thr_q};
        OFF_CNT: begin
          for (int unsigned i = 0; i < NUM_SRC; i++) rdata[i*CNT_W +: CNT_W] = cnt_q[i];
        end
        default: rdata = '0;
      endcase
    end
  end

  assign ahb.hrdata = rdata;
  assign ahb.hready = 1'b1;
  assign ahb.hresp  = 2'b00;

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      thr_q  <= CNT_W'(1);
      tmo_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      src_q  <= src_now;
      pend_q <= pend_d;
      mask_q <= mask_d;
      thr_q  <= thr_d;
      tmo_q  <= tmo_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  crypto_intr_coalesce #(
    .TIMER_W(TIMER_W),
    .CNT_W  (CNT_W)
  ) u_coalesce (
    .clk    (hclk),
    .rst_n  (hrst_b),
    .mev    (mev),
    .stat   (stat_nxt),
    .thr    (thr_q),
    .tmo    (tmo_q),
    .irq_out(irq_out)
  );

endmodule

// File: tb/tb_crypto_intr_ctrl.sv
// Directed bench for crypto_intr_ctrl: register reads go through an
// expected-value queue popped in the AHB data phase; irq timing checked per cycle.
module tb_crypto_intr_ctrl;

  logic hclk;
  logic hrst_b;
  logic rsa_intr, aes_intr, sha_intr;
  logic irq_out;

  crypto_intr_ctrl_if bus ();

  crypto_intr_ctrl #(
    .TIMER_W(16),
    .CNT_W  (8)
  ) dut (
    .hclk    (hclk),
    .hrst_b  (hrst_b),
    .ahb     (bus.slave),
    .rsa_intr(rsa_intr),
    .aes_intr(aes_intr),
    .sha_intr(sha_intr),
    .irq_out (irq_out)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
  endtask

  task automatic set_src(input logic [2:0] v);
    {sha_intr, aes_intr, rsa_intr} = v;
  endtask

  // Returns during the write data phase
  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = {24'h0, addr};
    @(posedge hclk); #1;
    bus_idle();
    bus.hwdata = data;
  endtask

  // Write whose data phase coincides with a source pulse
  task automatic wr_edge(input logic [7:0] addr, input logic [31:0] data, input logic [2:0] v);
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = {24'h0, addr};
    @(posedge hclk); #1;
    bus_idle();
    bus.hwdata = data;
    set_src(v);
    @(posedge hclk); #1;
    set_src(3'b000);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.haddr = {24'h0, addr};
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge hclk); #1;
    bus_idle();
    chk(tag_q.pop_front(), bus.hrdata, exp_q.pop_front());
  endtask

  // Source high for one cycle; returns one cycle after the edge cycle
  task automatic pulse(input logic [2:0] v);
    @(posedge hclk); #1;
    set_src(v);
    @(posedge hclk); #1;
    set_src(3'b000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hrst_b = 1'b0;
    set_src(3'b000);
    bus_idle();
    bus.haddr  = '0;
    bus.hsize  = 3'b010;
    bus.hprot  = 4'h0;
    bus.hwdata = '0;
    #12;
    chk("rst_irq", 32'(irq_out), 32'h0);
    chk("rst_hready", 32'(bus.hready), 32'h1);
    chk("rst_hresp", 32'(bus.hresp), 32'h0);
    chk("rst_hrdata", bus.hrdata, 32'h0);
    #10;
    hrst_b = 1'b1;

    rd(8'h00, 32'h0, "rst_raw");
    rd(8'h04, 32'h0, "rst_pend");
    rd(8'h08, 32'h0, "rst_mask");
    rd(8'h0C, 32'h0, "rst_stat");
    rd(8'h10, 32'h1, "rst_coal");
    rd(8'h14, 32'h0, "rst_cnt");
    rd(8'h18, 32'h0, "unmapped");

    // Single unmasked RSA pulse with THR=1
    wr(8'h08, 32'h1);
    pulse(3'b001);
    chk("rsa_irq_next", 32'(irq_out), 32'h1);
    rd(8'h04, 32'h1, "rsa_pend");
    rd(8'h14, 32'h1, "rsa_cnt");
    rd(8'h0C, 32'h1, "rsa_stat");
    wr(8'h04, 32'h1);
    chk("irq_hold_w1c", 32'(irq_out), 32'h1);
    @(posedge hclk); #1;
    chk("irq_clr_w1c", 32'(irq_out), 32'h0);
    rd(8'h04, 32'h0, "pend_cleared");

    // Threshold 3 with all sources unmasked
    wr(8'h10, 32'h3);
    wr(8'h08, 32'h7);
    wr(8'h14, 32'h0);
    rd(8'h10, 32'h3, "coal_thr3");
    pulse(3'b010);
    chk("thr_first_evt", 32'(irq_out), 32'h0);
    pulse(3'b101);
    chk("thr_reached", 32'(irq_out), 32'h1);
    rd(8'h04, 32'h7, "thr_pend");
    rd(8'h14, 32'h00010101, "thr_cnt");
    wr(8'h04, 32'h7);
    @(posedge hclk); #1;
    chk("thr_irq_clr", 32'(irq_out), 32'h0);

    // Timeout: THR=8, TMO=20
    wr(8'h10, 32'h00001408);
    pulse(3'b100);
    for (int i = 1; i <= 20; i++) begin
      chk("tmo_quiet", 32'(irq_out), 32'h0);
      @(posedge hclk); #1;
    end
    chk("tmo_fire", 32'(irq_out), 32'h1);
    wr(8'h04, 32'h4);
    @(posedge hclk); #1;
    chk("tmo_irq_clr", 32'(irq_out), 32'h0);

    // Masked sources, W1C/CNT-clear racing a new edge, counter saturation
    wr(8'h08, 32'h0);
    wr(8'h14, 32'h0);
    pulse(3'b010);
    chk("masked_no_irq", 32'(irq_out), 32'h0);
    rd(8'h04, 32'h2, "aes_pend");
    wr_edge(8'h04, 32'h2, 3'b010);
    rd(8'h04, 32'h2, "w1c_set_wins");
    wr_edge(8'h14, 32'h0, 3'b010);
    rd(8'h14, 32'h00000100, "cnt_clr_edge");
    wr(8'h14, 32'h0);
    for (int i = 0; i < 300; i++) pulse(3'b001);
    rd(8'h14, 32'h000000FF, "cnt_saturate");
    rd(8'h04, 32'h3, "pend_after_sat");
    chk("masked_irq_low", 32'(irq_out), 32'h0);

    // Asynchronous reset while waiting with PEND=0x5
    wr(8'h04, 32'h7);
    wr(8'h10, 32'h8);
    wr(8'h08, 32'h7);
    pulse(3'b101);
    chk("wait_irq_low", 32'(irq_out), 32'h0);
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.haddr = 32'h04;
    exp_q.push_back(32'h5);
    tag_q.push_back("wait_pend");
    @(posedge hclk); #1;
    bus_idle();
    chk(tag_q.pop_front(), bus.hrdata, exp_q.pop_front());
    #2;
    hrst_b = 1'b0;
    #1;
    chk("async_rst_hrdata", bus.hrdata, 32'h0);
    chk("async_rst_irq", 32'(irq_out), 32'h0);
    @(posedge hclk); #1;
    hrst_b = 1'b1;
    rd(8'h04, 32'h0, "post_rst_pend");
    rd(8'h08, 32'h0, "post_rst_mask");
    rd(8'h10, 32'h1, "post_rst_coal");
    rd(8'h14, 32'h0, "post_rst_cnt");
    chk("post_rst_irq", 32'(irq_out), 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crypto_intr_ctrl.md
# crypto_intr_ctrl

Interrupt aggregation and coalescing controller downstream of the crypto core's three interrupt outputs (RSA, AES, SHA). It captures rising edges of each source into W1C pending bits, applies a per-source mask, and coalesces events by count threshold or timeout into one CPU interrupt line. Software configures and services it through its own AHB-Lite slave window on the same bus segment as the crypto core.

## Interface
- TIMER_W, 16: coalescing timeout counter width.
- CNT_W, 8: per-source event counter width and threshold width.
- hclk  in  1  AHB clock; all logic on rising edge.
- hrst_b  in  1  reset; asynchronous, active-low.
- hsel  in  1  slave select for this window.
- haddr  in  32  byte address; only [7:2] decoded.
- htrans  in  2  transfer type; only NONSEQ/SEQ (htrans[1]=1) acted on.
- hwrite  in  1  1 = write.
- hsize  in  3  ignored; all accesses treated as 32-bit.
- hprot  in  4  ignored.
- hwdata  in  32  write data (data phase).
- hrdata  out  32  read data (data phase).
- hready  out  1  tied 1; zero wait states.
- hresp  out  2  tied 2'b00 (OKAY).
- rsa_intr, aes_intr, sha_intr  in  1 each  crypto core interrupts, synchronous to hclk, level or pulse.
- irq_out  out  1  coalesced interrupt to CPU, registered.

## Operation
- Source bit order everywhere: [0]=RSA, [1]=AES, [2]=SHA; bits [31:3] read 0.
- Edge capture: src_d <= {sha,aes,rsa}; edge = src & ~src_d.
- Register map (offset):
  - 0x00 RAW (RO): src_d.
  - 0x04 PEND (R/W1C): set by edge; written 1 clears. Set and clear same cycle: set wins.
  - 0x08 MASK (RW): reset 0.
  - 0x0C STAT (RO): PEND & MASK.
  - 0x10 COAL (RW): [7:0] THR, [23:8] TMO; reset THR=1, TMO=0.
  - 0x14 CNT (RO, any write clears all): [7:0]/[15:8]/[23:16] per-source edge counts, saturate at 255, independent of MASK. Edge coincident with clearing write: counter = 1.
  - Other offsets: read 0, writes ignored.
- AHB: address phase accepted when hsel & htrans[1] (hready always 1); addr and hwrite registered; write applied from hwdata in following cycle; hrdata combinationally muxed from registered address during read data phase, 0 otherwise.
- Coalescing FSM (IDLE, WAIT, ASSERT); mev = edge & MASK; n = popcount(mev):
  - IDLE: n>0 -> evt=n, tmr=0; if evt>=THR or THR<=1 -> ASSERT, else WAIT.
  - WAIT: evt += n (saturate 255); tmr++ (saturate); evt>=THR -> ASSERT; TMO!=0 and tmr==TMO -> ASSERT; STAT==0 (software cleared/masked) -> IDLE.
  - ASSERT: held until STAT==0 -> IDLE. New edges while ASSERT are not counted.
- irq_out <= (next_state == ASSERT).
- Reducing THR below current evt while in WAIT fires next cycle.

## Timing
- Reset: all registers 0 except THR=1; irq_out=0, hrdata=0, hready=1, hresp=00, state IDLE.
- Source rises at cycle t: PEND and CNT update at t+1; with THR=1 and unmasked, irq_out=1 at t+1.
- Write in data phase at t: register updated at t+1; readback available at t+1 data phase.
- W1C clearing last STAT bit at t: irq_out=0 at t+1 (unless new masked edge at t).
- Timeout: first event at t, TMO=N -> irq_out=1 at t+N+1.
- Reset mid-operation: immediate return to reset values, pending lost.

## Structure
- Shared include: register offsets, source bit indices, FSM state encodings.
- Sub-module crypto_intr_coalesce: FSM, evt and tmr counters; inputs mev, STAT, THR, TMO; output irq_out. Top holds AHB decode, edge detect, registers, counters.

## Test plan
- Reset, read all offsets -> 0 except COAL=0x00000001; irq_out=0.
- MASK=0x1, pulse rsa_intr 1 cycle -> PEND=0x1, CNT=0x01, irq_out=1 next cycle; write PEND=0x1 -> irq_out=0, PEND=0.
- COAL THR=3, MASK=0x7; pulse aes then rsa+sha simultaneously -> evt=3, irq_out=1 on second event +1 cycle.
- THR=8, TMO=20, one sha pulse -> irq_out=1 exactly 21 cycles later.
- W1C of AES coincident with new AES edge -> PEND[1] stays 1; 300 rsa pulses -> CNT[7:0]=255.
- hrst_b low while in WAIT with PEND=0x5 -> all outputs reset asynchronously; after release read PEND=0.
